// File: rtl/lif_neuron_multi.sv
// Multi-input leaky integrate-and-fire neuron with saturating membrane and refractory FSM.
// Define LIF_ADAPT_THRESH_EN to build the adaptive-threshold variant.
module lif_neuron_multi #(
  parameter int NUM_IN     = 4,
  parameter int W_WIDTH    = 8,
  parameter int V_WIDTH    = 16,
  parameter int THRESHOLD  = 20,
  parameter int LEAK       = 1,
  parameter int REFRACT    = 2,
  parameter int RESET_MODE = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [NUM_IN-1:0]           spike_in,
  input  logic [NUM_IN*W_WIDTH-1:0]   weights,
  output logic                        spike_out,
  output logic signed [V_WIDTH-1:0]   v_mem,
  output logic                        refractory,
  output logic signed [V_WIDTH-1:0]   thr_out
);

  localparam int SUM_W = V_WIDTH + $clog2(NUM_IN) + 2;
  localparam int CNT_W = (REFRACT > 1) ? $clog2(REFRACT + 1) : 1;

  localparam logic [0:0] ST_INTEGRATE  = 1'b0;
  localparam logic [0:0] ST_REFRACTORY = 1'b1;

  localparam logic signed [SUM_W-1:0] V_MAX    = {{(SUM_W-V_WIDTH+1){1'b0}}, {(V_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] V_MIN    = {{(SUM_W-V_WIDTH+1){1'b1}}, {(V_WIDTH-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] ZERO_S   = '0;
  localparam logic signed [SUM_W-1:0] LEAK_S   = SUM_W'(LEAK);
  localparam logic signed [V_WIDTH-1:0] THR_V  = V_WIDTH'(THRESHOLD);
  localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);

  // Clamp a wide intermediate into the signed membrane range; never wraps.
  function automatic logic signed [V_WIDTH-1:0] sat_v(input logic signed [SUM_W-1:0] x);
    if (x > V_MAX)      return V_MAX[V_WIDTH-1:0];
    else if (x < V_MIN) return V_MIN[V_WIDTH-1:0];
    else                return x[V_WIDTH-1:0];
  endfunction

  logic [0:0]                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic signed [V_WIDTH-1:0]  v_q, v_d;
  logic                       spike_q, spike_d;
  logic signed [V_WIDTH-1:0]  thr;

  logic signed [SUM_W-1:0]    sum, v_ext, lv, thr_ext;
  logic signed [V_WIDTH-1:0]  v_next;
  logic                       fire;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sum = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (spike_in[i]) sum = sum + SUM_W'($signed(weights[i*W_WIDTH +: W_WIDTH]));
    end
    v_ext   = SUM_W'(v_q);
    thr_ext = SUM_W'(thr);
    lv      = ZERO_S;
    if (v_ext > ZERO_S)      lv = (v_ext > LEAK_S) ? v_ext - LEAK_S : ZERO_S;
    else if (v_ext < ZERO_S) lv = (v_ext < -LEAK_S) ? v_ext + LEAK_S : ZERO_S;
    v_next = sat_v(lv + sum);
    fire   = (SUM_W'(v_next) >= thr_ext);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    v_d     = v_q;
    spike_d = 1'b0;
    if (en) begin
      case (state_q)
        ST_INTEGRATE: begin
          if (fire) begin
            spike_d = 1'b1;
            v_d     = (RESET_MODE == 1) ? sat_v(SUM_W'(v_next) - thr_ext) : '0;
            if (REFRACT > 0) begin
              state_d = ST_REFRACTORY;
              cnt_d   = CNT_W'(REFRACT);
            end
          end else begin
            v_d = v_next;
          end
        end
        ST_REFRACTORY: begin
          // Membrane is frozen; only the countdown moves.
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = ST_INTEGRATE;
        end
        default: state_d = ST_INTEGRATE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    if (rst) begin
      state_q <= ST_INTEGRATE;
      cnt_q   <= '0;
      v_q     <= '0;
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      spike_q <= spike_d;
    end
  end

`ifdef LIF_ADAPT_THRESH_EN
  localparam int ADAPT_STEP = 4;
  localparam logic signed [SUM_W-1:0]   ADAPT_S = SUM_W'(ADAPT_STEP);
  localparam logic signed [V_WIDTH-1:0] ONE_V   = V_WIDTH'(1);

  logic signed [V_WIDTH-1:0] thr_q, thr_d;

  // Each spike raises the bar; quiet enabled steps relax it back to the base value.
  always_comb begin
    thr_d = thr_q;
    if (en) begin
      if (spike_d)            thr_d = sat_v(thr_ext + ADAPT_S);
      else if (thr_q > THR_V) thr_d = thr_q - ONE_V;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) thr_q <= THR_V;
    else     thr_q <= thr_d;
  end

  assign thr = thr_q;
`else
  assign thr = THR_V;
`endif

  assign spike_out  = spike_q;
  assign v_mem      = v_q;
  assign refractory = (state_q == ST_REFRACTORY);
  assign thr_out    = thr;

endmodule
